sc_backg_scheduler: RTL and testbench
=====================================

SC_BACKG_SCHEDULER -- requirements
Module: sc_backg_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 12500000, sets the shift-tick period in clock cycles (4 Hz at 50 MHz); legal range 2..2^26-1.
REQ-002 SC_STATEMACHINEBACKG_CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 SC_STATEMACHINEBACKG_RESET_InHigh  in  1  asynchronous, active-high reset.
REQ-004 clear_req_InHigh  in  1  request to clear the background register.
REQ-005 load_req_InLow  in  1  request to load the background register (active low).
REQ-006 pause_InHigh  in  1  freezes the tick prescaler and blocks shifts.
REQ-007 level_In  in  3  game level; used only when the speed-up feature is compiled in.
REQ-008 clear_OutHigh  out  1  clear strobe to the background register.
REQ-009 load_OutLow  out  1  load strobe (active low).
REQ-010 shift_OutLow  out  1  shift/upcount strobe (active low).
REQ-011 busy_Out  out  1  high whenever the FSM is not in IDLE.
REQ-012 shift_count_Out  out  8  shifts since the last clear or load, saturating at 255.

Function
REQ-013 FSM states: CLEAR, IDLE, LOAD, HOLD, SHIFT; all outputs are Moore-decoded from the state register.
REQ-014 CLEAR: clear_OutHigh=1 for one cycle, shift_count=0, tick_pending=0, prescaler forced to 0, then IDLE.
REQ-015 IDLE priority: clear_req_InHigh=1 -> CLEAR; else load_req_InLow=0 -> LOAD; else tick_pending=1 and pause_InHigh=0 -> SHIFT; else IDLE.
REQ-016 LOAD: load_OutLow=0 for one cycle, shift_count=0, then HOLD.
REQ-017 HOLD: clear_req -> CLEAR; else stays while load_req_InLow=0, so a held button produces no repeat load; load_req_InLow=1 -> IDLE.
REQ-018 SHIFT: shift_OutLow=0 for one cycle, tick_pending cleared, shift_count incremented (saturating at 255), then IDLE.
REQ-019 Latency: a request sampled in IDLE at edge N produces its strobe in the cycle following edge N, exactly one cycle wide.
REQ-020 Prescaler counts 0..P-1 each cycle when not paused and not in CLEAR; at P-1 it wraps to 0 and sets tick_pending.
REQ-021 tick_pending is a single bit: a tick arriving while it is already set is dropped, not queued.
REQ-022 If the set and clear of tick_pending coincide on one edge (wrap during SHIFT), the set wins.
REQ-023 pause_InHigh holds the prescaler value and tick_pending; it does not block clear or load.
REQ-024 Non-encoded state values recover to CLEAR on the next edge.

Reset
REQ-025 While reset is asserted: state=CLEAR, clear_OutHigh=1, load_OutLow=1, shift_OutLow=1, busy_Out=1, shift_count_Out=0, prescaler=0, tick_pending=0.
REQ-026 The first cycle after reset release is CLEAR (cycle 0); IDLE follows at cycle 1.
REQ-027 Reset asserted mid-operation aborts any strobe immediately and returns the block to the REQ-025 values.

Configuration
REQ-028 Macro SC_BACKG_SCHEDULER_SPEEDUP_EN defined: P = max(TICK_DIV >> level_In, 2), with level_In sampled at each prescaler wrap.
REQ-029 Macro SC_BACKG_SCHEDULER_SPEEDUP_EN undefined: P = TICK_DIV, and level_In is ignored.

Verification (TICK_DIV=8, macro undefined unless stated)
REQ-030 Release reset with no requests -> clear_OutHigh=1 in cycle 0, shift_OutLow=0 in cycle 10 and again every 8 cycles (18, 26, ...); shift_count_Out increments by 1 per pulse.
REQ-031 Hold load_req_InLow=0 for 20 cycles starting in an IDLE cycle -> exactly one load_OutLow pulse, busy_Out high throughout the hold, shift_count_Out=0, IDLE one cycle after release.
REQ-032 Assert clear_req_InHigh and load_req_InLow=0 in the same IDLE cycle -> CLEAR strobe only, then LOAD on the following IDLE decision.
REQ-033 Assert pause_InHigh for 30 cycles -> no shift pulses and the prescaler value is frozen; after release the next pulse arrives after the remaining count, with no burst of missed ticks.
REQ-034 Hold load for 20 cycles (longer than P) -> one shift pulse is pending after HOLD exits, then normal cadence resumes; drive 300 ticks -> shift_count_Out saturates at 255.
REQ-035 Macro defined, level_In=2 -> shift pulses every 2 cycles (8>>2); level_In=7 -> period clamps to 2.

Source files
------------

// File: rtl/sc_backg_scheduler.sv
// Background-register strobe scheduler: clear, load and tick-driven shift.
// Optional level speed-up of the tick period: SC_BACKG_SCHEDULER_SPEEDUP_EN.
module sc_backg_scheduler #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic       SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic       SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic       clear_req_InHigh,
  input  logic       load_req_InLow,
  input  logic       pause_InHigh,
  input  logic [2:0] level_In,
  output logic       clear_OutHigh,
  output logic       load_OutLow,
  output logic       shift_OutLow,
  output logic       busy_Out,
  output logic [7:0] shift_count_Out
);

  localparam int PW = 26;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    SHIFT = 3'd4
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] period;
  logic          pending;
  logic          run;
  logic          wrap;

`ifdef SC_BACKG_SCHEDULER_SPEEDUP_EN
  logic [PW-1:0] scaled;
  logic [PW-1:0] period_nxt;

  always_comb begin
    scaled     = PW'(TICK_DIV >> level_In);
    period_nxt = (scaled < PW'(2)) ? PW'(2) : scaled;
  end
`else
  logic level_unused;

  assign level_unused = ^level_In;
  assign period       = PW'(TICK_DIV);
`endif

  assign run  = !pause_InHigh && (state != CLEAR);
  assign wrap = run && (presc >= period - PW'(1));

  always_comb begin
    nxt = CLEAR;
    unique case (state)
      CLEAR: nxt = IDLE;
      IDLE: begin
        if (clear_req_InHigh)
          nxt = CLEAR;
        else if (!load_req_InLow)
          nxt = LOAD;
        else if (pending && !pause_InHigh)
          nxt = SHIFT;
        else
          nxt = IDLE;
      end
      LOAD: nxt = HOLD;
      HOLD: begin
        if (clear_req_InHigh)
          nxt = CLEAR;
        else if (!load_req_InLow)
          nxt = HOLD;
        else
          nxt = IDLE;
      end
      SHIFT: nxt = IDLE;
      default: nxt = CLEAR;
    endcase
  end

  // Strobes are registered from the next state, so they track the state reg.
  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50
              or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      state           <= CLEAR;
      clear_OutHigh   <= 1'b1;
      load_OutLow     <= 1'b1;
      shift_OutLow    <= 1'b1;
      busy_Out        <= 1'b1;
      shift_count_Out <= 8'd0;
      presc           <= '0;
      pending         <= 1'b0;
`ifdef SC_BACKG_SCHEDULER_SPEEDUP_EN
      period          <= PW'(TICK_DIV);
`endif
    end else begin
      state         <= nxt;
      clear_OutHigh <= (nxt == CLEAR);
      load_OutLow   <= (nxt != LOAD);
      shift_OutLow  <= (nxt != SHIFT);
      busy_Out      <= (nxt != IDLE);

      if (state == CLEAR)
        presc <= '0;
      else if (wrap)
        presc <= '0;
      else if (run)
        presc <= presc + PW'(1);

      // A wrap landing on the SHIFT cycle keeps the new tick.
      if (wrap)
        pending <= 1'b1;
      else if (state == CLEAR || state == SHIFT)
        pending <= 1'b0;

      if (state == CLEAR || state == LOAD)
        shift_count_Out <= 8'd0;
      else if (state == SHIFT && shift_count_Out != 8'hff)
        shift_count_Out <= shift_count_Out + 8'd1;

`ifdef SC_BACKG_SCHEDULER_SPEEDUP_EN
      if (state == CLEAR || wrap)
        period <= period_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sc_backg_scheduler.sv
// Directed scoreboard bench for sc_backg_scheduler with TICK_DIV=8.
// Strobe events are queued as kind*100000+cycle and matched by a monitor.
module tb_sc_backg_scheduler;

  localparam int K_CLR = 1;
  localparam int K_LD  = 2;
  localparam int K_SH  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_req = 1'b0;
  logic       load_req = 1'b1;
  logic       pause = 1'b0;
  logic [2:0] level = 3'd0;
  logic       clr;
  logic       ld;
  logic       sh;
  logic       busy;
  logic [7:0] count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q[$];

  sc_backg_scheduler #(.TICK_DIV(8)) dut (
    .SC_STATEMACHINEBACKG_CLOCK_50    (clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh(rst),
    .clear_req_InHigh                 (clear_req),
    .load_req_InLow                   (load_req),
    .pause_InHigh                     (pause),
    .level_In                         (level),
    .clear_OutHigh                    (clr),
    .load_OutLow                      (ld),
    .shift_OutLow                     (sh),
    .busy_Out                         (busy),
    .shift_count_Out                  (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input int kind);
    int got;
    int want;
    got = kind * 100000 + cyc;
    if (exp_q.size() == 0) want = -1;
    else want = exp_q.pop_front();
    chk("strobe", got, want);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (clr) chk_ev(K_CLR);
      if (!ld) chk_ev(K_LD);
      if (!sh) chk_ev(K_SH);
    end
  end

  task automatic push(input int kind, input int c);
    exp_q.push_back(kind * 100000 + c);
  endtask

  task automatic to(input int c);
    int n;
    n = 0;
    while (cyc != c && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) chk("cycle_wait", cyc, c);
  endtask

  task automatic release_rst();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clear", int'(clr), 1);
    chk("rst_load", int'(ld), 1);
    chk("rst_shift", int'(sh), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_count", int'(count), 0);

    // Free-running cadence after reset
    push(K_CLR, 0);
    push(K_SH, 10);
    push(K_SH, 18);
    push(K_SH, 26);
    push(K_SH, 34);
    release_rst();
    to(11);
    chk("count_first", int'(count), 1);
    to(35);
    chk("count_four", int'(count), 4);
    chk("idle_busy", int'(busy), 0);
    chk("q_a", exp_q.size(), 0);

    // Held load: single pulse, tick left pending
    push(K_LD, 36);
    push(K_SH, 57);
    load_req = 1'b0;
    for (int c = 36; c <= 55; c++) begin
      to(c);
      chk("hold_busy", int'(busy), 1);
    end
    chk("hold_count", int'(count), 0);
    load_req = 1'b1;
    to(56);
    chk("hold_exit_idle", int'(busy), 0);
    to(58);
    chk("count_after_hold", int'(count), 1);
    chk("q_b", exp_q.size(), 0);

    // Clear and load together: clear wins, load follows
    to(60);
    push(K_CLR, 61);
    push(K_LD, 63);
    push(K_SH, 71);
    clear_req = 1'b1;
    load_req = 1'b0;
    to(61);
    clear_req = 1'b0;
    to(62);
    chk("post_clear_busy", int'(busy), 0);
    chk("post_clear_count", int'(count), 0);
    to(63);
    load_req = 1'b1;
    to(65);
    chk("post_load_idle", int'(busy), 0);

    // Pause freezes the prescaler
    to(72);
    chk("q_c", exp_q.size(), 0);
    push(K_SH, 109);
    pause = 1'b1;
    to(101);
    chk("pause_count", int'(count), 1);
    to(102);
    pause = 1'b0;
    to(110);
    chk("count_after_pause", int'(count), 2);
    chk("q_d", exp_q.size(), 0);

    // Long run to saturation
    for (int k = 0; k < 300; k++) push(K_SH, 117 + 8 * k);
    to(2133);
    chk("count_254", int'(count), 254);
    to(2134);
    chk("count_sat", int'(count), 255);
    to(2512);
    chk("count_hold_sat", int'(count), 255);
    chk("q_e", exp_q.size(), 0);

    // Reset during a shift strobe
    push(K_SH, 2517);
    to(2517);
    #2 rst = 1'b1;
    #1;
    chk("abort_shift", int'(sh), 1);
    chk("abort_clear", int'(clr), 1);
    chk("abort_load", int'(ld), 1);
    chk("abort_busy", int'(busy), 1);
    chk("abort_count", int'(count), 0);
    chk("q_f", exp_q.size(), 0);
    push(K_CLR, 0);
    push(K_SH, 10);
    release_rst();
    to(11);
    chk("rerun_count", int'(count), 1);
    chk("q_g", exp_q.size(), 0);

`ifdef SC_BACKG_SCHEDULER_SPEEDUP_EN
    for (int lv = 0; lv < 2; lv++) begin
      to(13);
      #2 rst = 1'b1;
      level = (lv == 0) ? 3'd2 : 3'd7;
      push(K_CLR, 0);
      for (int s = 4; s <= 12; s += 2) push(K_SH, s);
      release_rst();
      to(13);
      chk("speed_count", int'(count), 5);
      chk("speed_q", exp_q.size(), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
